// File: rtl/gate_op_arbiter_pkg.sv
// gate_ctrl_pkg: opcodes and result-register state encodings shared by the gate arbiter
package gate_ctrl_pkg;
  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
endpackage

// File: rtl/gate_op_arbiter_if.sv
// gate_op_arbiter_if: requester and response handshake bundle
//   req_valid/req_ready/req_op/req_a/req_b : NREQ requesters, packed per requester
//   resp_valid/resp_ready/resp_id/resp_op/resp_data : single result port
interface gate_op_arbiter_if #(
  parameter int W = 8,
  parameter int NREQ = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic resp_valid;
  logic resp_ready;
  logic [IDW-1:0] resp_id;
  logic [1:0] resp_op;
  logic [W-1:0] resp_data;
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_op, resp_data
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_op, resp_data
  );
endinterface

// File: rtl/gate_unit.sv
// gate_unit: combinational W-bit NAND/NOR/XOR/XNOR selected by op
//   op : opcode, a/b : operands, y : bitwise result
module gate_unit
  import gate_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb y = op == OP_NAND ? ~(a & b) :
                  op == OP_NOR  ? ~(a | b) :
                  op == OP_XOR  ? a ^ b : ~(a ^ b);
endmodule

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin sharing of one gate unit among NREQ requesters
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requester handshakes in, registered result out (slave side)
//   op_count   : completed response handshakes, wraps at 16 bits
module gate_op_arbiter
  import gate_ctrl_pkg::*;
#(
  parameter int W = 8,
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_op_arbiter_if.slave  bus,
  output logic [15:0]       op_count
);
  state_t state, state_n;
  logic [IDW-1:0] ptr, gnt, c;
  logic hit, accept;
  logic [1:0] g_op;
  logic [W-1:0] g_a, g_b, g_y;
  // search starts just past the last winner so every requester gets a turn
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    c = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IDW'((int'(ptr) + k) % NREQ);
      if (!hit && bus.req_valid[c]) begin
        hit = 1'b1;
        gnt = c;
      end
    end
    accept = rst_n && hit && (state == ST_EMPTY || bus.resp_ready);
    state_n = accept ? ST_FULL : bus.resp_ready ? ST_EMPTY : state;
    bus.req_ready = accept ? NREQ'(1) << gnt : '0;
  end
  assign g_op = bus.req_op[2*gnt +: 2];
  assign g_a = bus.req_a[W*gnt +: W];
  assign g_b = bus.req_b[W*gnt +: W];
  assign bus.resp_valid = state == ST_FULL;
  gate_unit #(.W(W)) u_gate (.op(g_op), .a(g_a), .b(g_b), .y(g_y));
  always_ff @(posedge clk)
    state <= !rst_n ? ST_EMPTY : state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
      bus.resp_id <= '0;
      bus.resp_op <= '0;
      bus.resp_data <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        ptr <= gnt;
        bus.resp_id <= gnt;
        bus.resp_op <= g_op;
        bus.resp_data <= g_y;
      end
      if (bus.resp_valid && bus.resp_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter: scoreboarded random and directed checks of gate_op_arbiter
module tb_gate_op_arbiter;
  localparam int W = 8;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0] op;
    logic [W-1:0] data;
  } rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] op_count;
  rsp_t q[$];
  int checks = 0;
  int errors = 0;
  int last = NREQ - 1;
  int acc_now = 0;
  int hs = 0;
  logic [15:0] mcnt = '0;
  logic [NREQ-1:0] last_ready;
  logic [NREQ-1:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [W-1:0] op_exp [4] = '{8'hCF, 8'h03, 8'hCC, 8'h33};
  logic [3:0] tts [4] = '{4'b0111, 4'b0001, 4'b0110, 4'b1001};

  gate_op_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();
  gate_op_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-bit truth table lookup, indexed by {a,b}
  function automatic logic [W-1:0] ref_gate(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0] tt;
    logic [W-1:0] y;
    tt = tts[op];
    for (int i = 0; i < W; i++) y[i] = tt[{a[i], b[i]}];
    return y;
  endfunction

  // evaluate one cycle's inputs against the reference model, then advance to posedge+1
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    int g;
    #1;
    exp_ready = '0;
    acc_now = 0;
    g = -1;
    if (!rst_n) begin
      q.delete();
      last = NREQ - 1;
    end else if (q.size() == 0 || bus.resp_ready) begin
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && bus.req_valid[(last + k) % NREQ]) g = (last + k) % NREQ;
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    last_ready = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (g >= 0) begin
      q.push_back('{id: IDW'(g), op: bus.req_op[2*g +: 2],
                    data: ref_gate(bus.req_op[2*g +: 2], bus.req_a[W*g +: W], bus.req_b[W*g +: W])});
      last = g;
      acc_now = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: compares the presented result against the queue head, pops on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = '0;
      hs = 0;
    end else begin
      chk("resp_valid", 32'(bus.resp_valid), 32'((q.size() - acc_now) > 0));
      if (bus.resp_valid && q.size() > 0) begin
        chk("resp_id", 32'(bus.resp_id), 32'(q[0].id));
        chk("resp_op", 32'(bus.resp_op), 32'(q[0].op));
        chk("resp_data", 32'(bus.resp_data), 32'(q[0].data));
      end
      chk("op_count", 32'(op_count), 32'(mcnt));
      if (bus.resp_valid && bus.resp_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        mcnt = mcnt + 16'd1;
        hs++;
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = '1;
    bus.req_op = 8'hE4;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    tick();
    tick();
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_grant", 32'(last_ready), 32'(rr_exp[i]));
    end
    chk("rr_resp_id", 32'(bus.resp_id), 32'd1);
    bus.req_valid = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 4'b0100;
      bus.req_op = 8'(k << 4);
      bus.req_a = 32'h00F0_0000;
      bus.req_b = 32'h003C_0000;
      tick();
      chk("op_grant", 32'(last_ready), 32'h4);
      chk("op_data", 32'(bus.resp_data), 32'(op_exp[k]));
      chk("op_id", 32'(bus.resp_id), 32'd2);
    end
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '1;
    bus.resp_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_ready", 32'(last_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("drain_accept_valid", 32'(bus.resp_valid), 32'd1);
    bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midop_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midop_op_count", 32'(op_count), 32'd0);
    bus.req_valid = 4'b1010;
    bus.resp_ready = 1'b1;
    tick();
    chk("midop_first_grant", 32'(last_ready), 32'h2);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      bus.req_valid = NREQ'($urandom);
      bus.req_op = 8'($urandom);
      bus.req_a = $urandom;
      bus.req_b = $urandom;
      bus.resp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req_valid = '1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 70000 && hs < 65537; i++) tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    chk("wrap_handshakes", 32'(hs), 32'd65537);
    chk("wrap_op_count", 32'(op_count), 32'd1);
    tick();
    tick();
    chk("stall_op_count", 32'(op_count), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_op_arbiter.md
# gate_op_arbiter

Round-robin controller that shares one W-bit universal-gate unit (NAND/NOR/XOR/XNOR) among NREQ requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The block grants at most one requester per cycle and registers the result with the winner's ID. The result is returned on a single valid/ready response port with backpressure. It sits between software-visible operand sources and the bitwise gate datapath, and also keeps a running count of completed operations.

## Interface
- W, 8, operand/result width in bits (1..32)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester-ID width; must equal clog2(NREQ)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- req_valid  in  NREQ  bit i: requester i has an operation pending
- req_ready  out  NREQ  bit i: requester i's operation is accepted this cycle (at most one bit set)
- req_op  in  2*NREQ  requester i opcode at [2i+:2]
- req_a  in  W*NREQ  requester i operand A at [i*W+:W]
- req_b  in  W*NREQ  requester i operand B at [i*W+:W]
- resp_valid  out  1  result register holds a result
- resp_ready  in  1  consumer accepts the result
- resp_id  out  IDW  index of the requester that produced the result
- resp_op  out  2  opcode of the result
- resp_data  out  W  bitwise result
- op_count  out  16  number of completed response handshakes, wraps

## Operation
- Opcodes: 00 NAND, 01 NOR, 10 XOR, 11 XNOR. All are bitwise across W bits.
- FSM with two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = EMPTY, or (FULL and resp_ready).
- Arbitration: when can_accept, grant the first i with req_valid[i]=1, searching from ptr+1 upward modulo NREQ.
  - req_ready[grant]=1 combinationally in that cycle; all other bits are 0.
  - req_ready may depend on req_valid.
- On accept: at the next edge, resp_data = f(op, a, b), resp_id = grant, resp_op = op, state = FULL, ptr = grant.
- Drain without a new accept (FULL, resp_ready=1, no req_valid): go to EMPTY. resp_data/id/op hold their last values.
- Stall (FULL, resp_ready=0): resp_valid/id/op/data stay stable, req_ready=0.
- Simultaneous drain and accept: new result loaded, resp_valid stays 1; throughput is 1 op/cycle.
- op_count increments on every resp_valid&&resp_ready edge and wraps from 0xFFFF to 0x0000.
- Requester valid that drops before it is granted is legal; it is simply not considered.

## Timing
- Reset values (rst_n=0 at an edge):
  - resp_valid=0, resp_id=0, resp_op=0, resp_data=0, op_count=0, state=EMPTY.
  - ptr=NREQ-1, so requester 0 has first priority.
- req_ready=0 while rst_n=0, regardless of req_valid.
- Latency: an accept in cycle N gives resp_valid=1 with the result in cycle N+1.
- Reset mid-operation: a pending result is discarded and not counted. The first grant after release follows reset priority.
- No combinational path from resp_ready to resp_* outputs. resp_ready→req_ready is combinational.

## Structure
- Package gate_ctrl_pkg holds:
  - opcode constants OP_NAND/OP_NOR/OP_XOR/OP_XNOR (2-bit)
  - state encodings ST_EMPTY/ST_FULL
- Sub-module gate_unit: purely combinational, W-bit, inputs op/a/b, output y. It is instantiated once.
- Arbiter, pointer, result register and counter live in gate_op_arbiter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 → req_ready=0000, resp_valid=0, op_count=0. The first cycle after release gives req_ready=0001, and resp_id=0 one cycle later.
- Opcodes: requester 2 alone, a=0xF0, b=0x3C, resp_ready=1. Ops 00/01/10/11 → resp_data 0xCF/0x03/0xCC/0x33, resp_id=2, each one cycle after req_ready=0100.
- Round-robin: all four requesters valid continuously, resp_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles. resp_id follows one cycle later, and op_count advances by 1 per cycle.
- Backpressure: result pending with resp_ready=0 for 3 cycles → resp_* stable, req_ready=0000. On resp_ready=1 the drain and the next grant occur in the same cycle, and resp_valid stays 1.
- Counter wrap: 65537 response handshakes → op_count=0x0001. A stalled cycle does not increment it.
- Reset mid-op: rst_n=0 for one cycle while resp_valid=1 and resp_ready=0 → next cycle resp_valid=0 and op_count=0. The next grant goes to the lowest valid index.
